// File: rtl/mxrv_csr_pkg.sv
// mxrv_csr_pkg: shared constants for the mxrv machine-mode CSR file.
//   - CSR address map
//   - csr_op encoding (matches funct3[1:0] of CSRRW/CSRRS/CSRRC)
//   - mstatus / mie / mip bit positions
//   - reset values of the writable CSRs
package mxrv_csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_FFLAGS    = 12'h001;
  localparam logic [11:0] CSR_FRM       = 12'h002;
  localparam logic [11:0] CSR_FCSR      = 12'h003;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int IRQ_MSI = 3;
  localparam int IRQ_MTI = 7;
  localparam int IRQ_MEI = 11;

  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  localparam logic [31:0] MTVEC_RST    = 32'h0;
  localparam logic [31:0] MEPC_RST     = 32'h0;
  localparam logic [31:0] MCAUSE_RST   = 32'h0;
  localparam logic [31:0] MTVAL_RST    = 32'h0;
  localparam logic [31:0] MSCRATCH_RST = 32'h0;
  localparam logic [31:0] MIE_RST      = 32'h0;
  localparam logic [7:0]  FCSR_RST     = 8'h0;

endpackage

// File: rtl/mxrv_csr_counter.sv
// mxrv_csr_counter: CNT_WIDTH-bit free-running counter exposed as two
// 32-bit CSR halves.
//   clk, rst_n        clock, async active-low reset
//   inc_i             increment enable
//   wr_lo_i, wr_hi_i  replace bits [31:0] / [CNT_WIDTH-1:32] with wdata_i
//   wdata_i           write data
//   lo_o, hi_o        bits [31:0] and zero-extended upper bits (0 if none)
// A write in the same cycle as an increment wins and the untouched half
// keeps its value (no carry is generated by the write).
module mxrv_csr_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] lo_o,
  output logic [31:0] hi_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  if (CNT_WIDTH > 32) begin : g_wide
    always_comb begin
      cnt_d = cnt_q;
      if (wr_lo_i)      cnt_d = {cnt_q[CNT_WIDTH-1:32], wdata_i};
      else if (wr_hi_i) cnt_d = {wdata_i[CNT_WIDTH-33:0], cnt_q[31:0]};
      else if (inc_i)   cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    assign hi_o = 32'(cnt_q[CNT_WIDTH-1:32]);
  end else begin : g_narrow
    always_comb begin
      cnt_d = cnt_q;
      if (wr_lo_i)    cnt_d = wdata_i;
      else if (inc_i) cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    assign hi_o = '0;
  end

  assign lo_o = cnt_q[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mxrv_csr_file.sv
// mxrv_csr_file: machine-mode CSR file for the mxrv core.
//   csr_req_i/op/addr/wdata     CSR instruction (RW/RS/RC), one per cycle
//   csr_rdata_o/rvalid/illegal  registered old value + legality, 1 cycle later
//   retire_i                    instret increment
//   trap_i/cause/pc/tval        trap entry (highest priority)
//   mret_i                      return from trap
//   irq_sw/timer/ext_i          level interrupt sources (form mip)
//   mtvec_o, mepc_o             current trap vector / return PC
//   irq_pending_o               mstatus.MIE & |(mie & mip), combinational
// Build option: define MXRV_CSR_FPU_EN to add fflags/frm/fcsr backed by one
// shared 8-bit register; otherwise those addresses are unimplemented.
module mxrv_csr_file
  import mxrv_csr_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          CNT_WIDTH = 64,
  parameter int unsigned HART_ID   = 0,
  parameter logic [31:0] MISA_VAL  = 32'h4000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_req_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_rvalid_o,
  output logic            csr_illegal_o,
  input  logic            retire_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_i,
  input  logic            irq_sw_i,
  input  logic            irq_timer_i,
  input  logic            irq_ext_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            irq_pending_o
);

  csr_op_e         op;
  logic            req, impl, ro, wr_attempt, wr_en;
  logic [XLEN-1:0] old_val, wr_val, mstatus_val, mip_val;
  logic [31:0]     cyc_lo, cyc_hi, ins_lo, ins_hi;

  logic            mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d, illegal_q, illegal_d;
`ifdef MXRV_CSR_FPU_EN
  logic [7:0]      fcsr_q, fcsr_d;
`endif

  assign op  = csr_op_e'(csr_op_i);
  assign req = csr_req_i && (op != CSR_OP_NONE);

  always_comb begin
    mstatus_val                               = '0;
    mstatus_val[MSTATUS_MIE]                  = mst_mie_q;
    mstatus_val[MSTATUS_MPIE]                 = mst_mpie_q;
    mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mip_val          = '0;
    mip_val[IRQ_MSI] = irq_sw_i;
    mip_val[IRQ_MTI] = irq_timer_i;
    mip_val[IRQ_MEI] = irq_ext_i;
  end

  // Read mux; unimplemented addresses fall through to default and read 0.
  always_comb begin
    old_val = '0;
    impl    = 1'b1;
    ro      = 1'b0;
    case (csr_addr_i)
`ifdef MXRV_CSR_FPU_EN
      CSR_FFLAGS:    old_val = XLEN'(fcsr_q[4:0]);
      CSR_FRM:       old_val = XLEN'(fcsr_q[7:5]);
      CSR_FCSR:      old_val = XLEN'(fcsr_q);
`endif
      CSR_MSTATUS:   old_val = mstatus_val;
      CSR_MIE:       old_val = mie_q;
      CSR_MTVEC:     old_val = mtvec_q;
      CSR_MSCRATCH:  old_val = mscratch_q;
      CSR_MEPC:      old_val = mepc_q;
      CSR_MCAUSE:    old_val = mcause_q;
      CSR_MTVAL:     old_val = mtval_q;
      CSR_MCYCLE:    old_val = cyc_lo;
      CSR_MCYCLEH:   old_val = cyc_hi;
      CSR_MINSTRET:  old_val = ins_lo;
      CSR_MINSTRETH: old_val = ins_hi;
      CSR_MISA:      begin old_val = MISA_VAL;       ro = 1'b1; end
      CSR_MHARTID:   begin old_val = XLEN'(HART_ID); ro = 1'b1; end
      CSR_MIP:       begin old_val = mip_val;        ro = 1'b1; end
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: ro = 1'b1;
      default:       impl = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      CSR_OP_RW: wr_val = csr_wdata_i;
      CSR_OP_RS: wr_val = old_val | csr_wdata_i;
      CSR_OP_RC: wr_val = old_val & ~csr_wdata_i;
      default:   wr_val = old_val;
    endcase
  end

  // RS/RC with zero operand is a pure read, so it is legal on read-only CSRs.
  assign wr_attempt = (op == CSR_OP_RW) || (csr_wdata_i != '0);
  assign wr_en      = req && impl && !ro && wr_attempt && !trap_i && !mret_i;

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
`ifdef MXRV_CSR_FPU_EN
    fcsr_d     = fcsr_q;
`endif
    if (trap_i) begin
      mepc_d     = {trap_pc_i[XLEN-1:2], 2'b00};
      mcause_d   = trap_cause_i;
      mtval_d    = trap_tval_i;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (mret_i) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr_i)
`ifdef MXRV_CSR_FPU_EN
        CSR_FFLAGS:   fcsr_d[4:0] = wr_val[4:0];
        CSR_FRM:      fcsr_d[7:5] = wr_val[2:0];
        CSR_FCSR:     fcsr_d      = wr_val[7:0];
`endif
        CSR_MSTATUS: begin
          mst_mie_d  = wr_val[MSTATUS_MIE];
          mst_mpie_d = wr_val[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_d      = wr_val & MIE_MASK;
        CSR_MTVEC:    mtvec_d    = {wr_val[XLEN-1:2], 2'b00};
        CSR_MSCRATCH: mscratch_d = wr_val;
        CSR_MEPC:     mepc_d     = {wr_val[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = wr_val;
        CSR_MTVAL:    mtval_d    = wr_val;
        default: ;
      endcase
    end
  end

  always_comb begin
    rvalid_d  = req;
    illegal_d = req && (!impl || (ro && wr_attempt));
    rdata_d   = req ? old_val : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= MIE_RST;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= MSCRATCH_RST;
      mepc_q     <= MEPC_RST;
      mcause_q   <= MCAUSE_RST;
      mtval_q    <= MTVAL_RST;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      illegal_q  <= illegal_d;
    end
  end

`ifdef MXRV_CSR_FPU_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fcsr_q <= FCSR_RST;
    else        fcsr_q <= fcsr_d;
  end
`endif

  mxrv_csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (1'b1),
    .wr_lo_i (wr_en && (csr_addr_i == CSR_MCYCLE)),
    .wr_hi_i (wr_en && (csr_addr_i == CSR_MCYCLEH)),
    .wdata_i (wr_val),
    .lo_o    (cyc_lo),
    .hi_o    (cyc_hi)
  );

  mxrv_csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_instret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (retire_i),
    .wr_lo_i (wr_en && (csr_addr_i == CSR_MINSTRET)),
    .wr_hi_i (wr_en && (csr_addr_i == CSR_MINSTRETH)),
    .wdata_i (wr_val),
    .lo_o    (ins_lo),
    .hi_o    (ins_hi)
  );

  assign csr_rdata_o   = rdata_q;
  assign csr_rvalid_o  = rvalid_q;
  assign csr_illegal_o = illegal_q;
  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign irq_pending_o = mst_mie_q && |(mie_q & mip_val);

endmodule

// File: tb/tb_mxrv_csr_file.sv
// Testbench for mxrv_csr_file: scoreboard of expected read responses,
// one task per scenario. A second instance with CNT_WIDTH=32 shares the
// stimulus and is only inspected for the upper counter half.
module tb_mxrv_csr_file;

  localparam logic [1:0] OP_NONE = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11;
  localparam logic [11:0] A_FFLAGS = 12'h001, A_FRM = 12'h002, A_FCSR = 12'h003;
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MISA = 12'h301, A_MIE = 12'h304;
  localparam logic [11:0] A_MTVEC = 12'h305, A_MSCRATCH = 12'h340, A_MEPC = 12'h341;
  localparam logic [11:0] A_MCAUSE = 12'h342, A_MTVAL = 12'h343, A_MIP = 12'h344;
  localparam logic [11:0] A_MCYCLE = 12'hB00, A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH = 12'hB80, A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MVENDORID = 12'hF11, A_MHARTID = 12'hF14;
  localparam logic [31:0] MISA_EXP = 32'h4000_0100;

  logic        clk, rst_n;
  logic        csr_req_i, retire_i, trap_i, mret_i;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i, trap_cause_i, trap_pc_i, trap_tval_i;
  logic        irq_sw_i, irq_timer_i, irq_ext_i;
  logic [31:0] csr_rdata_o, mtvec_o, mepc_o;
  logic        csr_rvalid_o, csr_illegal_o, irq_pending_o;
  logic [31:0] rdata32, mtvec32, mepc32;
  logic        rvalid32, illegal32, pending32;

  mxrv_csr_file dut (
    .clk(clk), .rst_n(rst_n), .csr_req_i(csr_req_i), .csr_op_i(csr_op_i),
    .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
    .csr_rvalid_o(csr_rvalid_o), .csr_illegal_o(csr_illegal_o), .retire_i(retire_i),
    .trap_i(trap_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
    .trap_tval_i(trap_tval_i), .mret_i(mret_i), .irq_sw_i(irq_sw_i),
    .irq_timer_i(irq_timer_i), .irq_ext_i(irq_ext_i), .mtvec_o(mtvec_o),
    .mepc_o(mepc_o), .irq_pending_o(irq_pending_o)
  );

  mxrv_csr_file #(.CNT_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .csr_req_i(csr_req_i), .csr_op_i(csr_op_i),
    .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .csr_rdata_o(rdata32),
    .csr_rvalid_o(rvalid32), .csr_illegal_o(illegal32), .retire_i(retire_i),
    .trap_i(trap_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
    .trap_tval_i(trap_tval_i), .mret_i(mret_i), .irq_sw_i(irq_sw_i),
    .irq_timer_i(irq_timer_i), .irq_ext_i(irq_ext_i), .mtvec_o(mtvec32),
    .mepc_o(mepc32), .irq_pending_o(pending32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        illegal;
    bit          chk_data;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Responses are due at the negedge following the sampling posedge.
  always @(negedge clk) begin
    if (csr_rvalid_o) begin
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid 1 expected 0");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        if (csr_illegal_o !== e.illegal) begin
          errors++;
          $display("FAIL %s illegal: got %b expected %b", e.name, csr_illegal_o, e.illegal);
        end
        if (e.chk_data) begin
          checks++;
          if (csr_rdata_o !== e.rdata) begin
            errors++;
            $display("FAIL %s rdata: got %h expected %h", e.name, csr_rdata_o, e.rdata);
          end
        end
      end
    end else if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s rvalid: got 0 expected 1", e.name);
    end
  end

  task automatic csr_do(input logic [1:0] op, input logic [11:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_ill, input bit chk, input string name);
    exp_t e;
    csr_req_i   = 1'b1;
    csr_op_i    = op;
    csr_addr_i  = addr;
    csr_wdata_i = wdata;
    @(posedge clk);
    e.rdata = exp_rdata; e.illegal = exp_ill; e.chk_data = chk; e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    csr_req_i   = 1'b0;
    csr_op_i    = OP_NONE;
    csr_wdata_i = '0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (csr_rdata_o !== 32'h0 || csr_rvalid_o !== 1'b0 || csr_illegal_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdata %h rvalid %b illegal %b expected 0 0 0",
               csr_rdata_o, csr_rvalid_o, csr_illegal_o);
    end
    checks++;
    if (mtvec_o !== 32'h0 || mepc_o !== 32'h0 || irq_pending_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: got mtvec %h mepc %h pend %b expected 0 0 0",
               mtvec_o, mepc_o, irq_pending_o);
    end
    csr_do(OP_RS, A_MSTATUS, 32'h0, 32'h0000_1800, 1'b0, 1, "reset_mstatus");
    csr_do(OP_RS, A_MSCRATCH, 32'h0, 32'h0, 1'b0, 1, "reset_mscratch");
    csr_do(OP_RS, A_MIE, 32'h0, 32'h0, 1'b0, 1, "reset_mie");
    idle();
  endtask

  task automatic test_rw_rs_rc();
    csr_do(OP_RW, A_MSCRATCH, 32'h1234_5678, 32'h0, 1'b0, 1, "mscratch_rw");
    idle();
    csr_do(OP_RS, A_MSCRATCH, 32'h0000_000F, 32'h1234_5678, 1'b0, 1, "mscratch_rs");
    idle();
    csr_do(OP_RC, A_MSCRATCH, 32'h0000_0008, 32'h1234_567F, 1'b0, 1, "mscratch_rc");
    idle();
    csr_do(OP_RS, A_MSCRATCH, 32'h0, 32'h1234_5677, 1'b0, 1, "mscratch_read");
    idle();
  endtask

  task automatic test_idle_hold();
    idle();
    checks++;
    if (csr_rdata_o !== 32'h1234_5677 || csr_rvalid_o !== 1'b0 || csr_illegal_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got rdata %h rvalid %b illegal %b expected 12345677 0 0",
               csr_rdata_o, csr_rvalid_o, csr_illegal_o);
    end
  endtask

  task automatic test_illegal();
    csr_do(OP_RW, A_MISA, 32'hFFFF_FFFF, MISA_EXP, 1'b1, 1, "misa_rw");
    csr_do(OP_RS, A_MISA, 32'h0, MISA_EXP, 1'b0, 1, "misa_read");
    csr_do(OP_RS, A_MISA, 32'h1, MISA_EXP, 1'b1, 1, "misa_rs_nz");
    csr_do(OP_RW, 12'h7C0, 32'h5, 32'h0, 1'b1, 1, "unimpl_7c0");
    csr_do(OP_RS, A_MHARTID, 32'h0, 32'h0, 1'b0, 1, "mhartid");
    csr_do(OP_RC, A_MVENDORID, 32'h0, 32'h0, 1'b0, 1, "mvendorid");
    csr_do(OP_RW, A_MIP, 32'h888, 32'h0, 1'b1, 1, "mip_rw");
`ifdef MXRV_CSR_FPU_EN
    csr_do(OP_RW, A_FCSR, 32'hE5, 32'h0, 1'b0, 1, "fcsr_rw");
    csr_do(OP_RS, A_FFLAGS, 32'h0, 32'h05, 1'b0, 1, "fflags_alias");
    csr_do(OP_RW, A_FRM, 32'h2, 32'h7, 1'b0, 1, "frm_rw");
    csr_do(OP_RS, A_FCSR, 32'h0, 32'h45, 1'b0, 1, "fcsr_alias");
`else
    csr_do(OP_RS, A_FFLAGS, 32'h0, 32'h0, 1'b1, 1, "fflags_absent");
    csr_do(OP_RW, A_FCSR, 32'hFF, 32'h0, 1'b1, 1, "fcsr_absent");
    csr_do(OP_RS, A_FRM, 32'h0, 32'h0, 1'b1, 1, "frm_absent");
`endif
    csr_do(OP_RS, A_MISA, 32'h0, MISA_EXP, 1'b0, 1, "misa_unchanged");
    idle();
  endtask

  task automatic test_fields();
    csr_do(OP_RW, A_MSTATUS, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0, 1, "mstatus_rw");
    csr_do(OP_RW, A_MIE, 32'hFFFF_FFFF, 32'h0, 1'b0, 1, "mie_rw");
    csr_do(OP_RS, A_MIE, 32'h0, 32'h0000_0888, 1'b0, 1, "mie_mask");
    csr_do(OP_RW, A_MTVEC, 32'h0000_1003, 32'h0, 1'b0, 1, "mtvec_rw");
    csr_do(OP_RW, A_MEPC, 32'h0000_0207, 32'h0, 1'b0, 1, "mepc_rw");
    csr_do(OP_RS, A_MSTATUS, 32'h0, 32'h0000_1888, 1'b0, 1, "mstatus_mask");
    checks++;
    if (mtvec_o !== 32'h0000_1000 || mepc_o !== 32'h0000_0204) begin
      errors++;
      $display("FAIL low_bits: got mtvec %h mepc %h expected 00001000 00000204", mtvec_o, mepc_o);
    end
    csr_do(OP_RW, A_MIE, 32'h0, 32'h0000_0888, 1'b0, 1, "mie_clear");
    csr_do(OP_RW, A_MSTATUS, 32'h0, 32'h0000_1888, 1'b0, 1, "mstatus_clear");
    idle();
  endtask

  task automatic test_trap_mret();
    csr_do(OP_RW, A_MSTATUS, 32'h8, 32'h0000_1800, 1'b0, 1, "set_mie");
    trap_i = 1'b1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h100; trap_tval_i = 32'hABC;
    idle();
    trap_i = 1'b0;
    checks++;
    if (mepc_o !== 32'h100) begin
      errors++;
      $display("FAIL trap_mepc: got %h expected 00000100", mepc_o);
    end
    csr_do(OP_RS, A_MCAUSE, 32'h0, 32'h8000_0007, 1'b0, 1, "trap_mcause");
    csr_do(OP_RS, A_MTVAL, 32'h0, 32'h0000_0ABC, 1'b0, 1, "trap_mtval");
    csr_do(OP_RS, A_MSTATUS, 32'h0, 32'h0000_1880, 1'b0, 1, "trap_mstatus");
    mret_i = 1'b1;
    idle();
    mret_i = 1'b0;
    csr_do(OP_RS, A_MSTATUS, 32'h0, 32'h0000_1888, 1'b0, 1, "mret_mstatus");
    idle();
  endtask

  task automatic test_collision();
    trap_i = 1'b1; trap_cause_i = 32'h2; trap_pc_i = 32'h30A; trap_tval_i = 32'h0;
    csr_do(OP_RW, A_MEPC, 32'h200, 32'h100, 1'b0, 1, "trap_vs_write");
    trap_i = 1'b0;
    checks++;
    if (mepc_o !== 32'h308) begin
      errors++;
      $display("FAIL trap_drops_write: got mepc %h expected 00000308", mepc_o);
    end
    mret_i = 1'b1;
    csr_do(OP_RW, A_MSCRATCH, 32'hDEAD, 32'h1234_5677, 1'b0, 1, "mret_vs_write");
    mret_i = 1'b0;
    csr_do(OP_RS, A_MSCRATCH, 32'h0, 32'h1234_5677, 1'b0, 1, "mret_drops_write");
    csr_do(OP_RS, A_MSTATUS, 32'h0, 32'h0000_1888, 1'b0, 1, "collision_mstatus");
    idle();
  endtask

  task automatic test_irq();
    csr_do(OP_RW, A_MIE, 32'h80, 32'h0, 1'b0, 1, "irq_mie");
    csr_do(OP_RW, A_MSTATUS, 32'h0, 32'h0000_1888, 1'b0, 1, "irq_mie_off");
    irq_timer_i = 1'b1;
    idle();
    checks++;
    if (irq_pending_o !== 1'b0) begin
      errors++;
      $display("FAIL irq_gated: got %b expected 0", irq_pending_o);
    end
    csr_req_i = 1'b1; csr_op_i = OP_RS; csr_addr_i = A_MSTATUS; csr_wdata_i = 32'h8;
    @(posedge clk);
    begin
      exp_t e;
      e.rdata = 32'h0000_1800; e.illegal = 1'b0; e.chk_data = 1; e.name = "irq_set_mie";
      sb_q.push_back(e);
    end
    #1;
    checks++;
    if (irq_pending_o !== 1'b1) begin
      errors++;
      $display("FAIL irq_enabled: got %b expected 1", irq_pending_o);
    end
    @(negedge clk);
    irq_timer_i = 1'b0;
    irq_ext_i   = 1'b1;
    idle();
    checks++;
    if (irq_pending_o !== 1'b0) begin
      errors++;
      $display("FAIL irq_masked: got %b expected 0", irq_pending_o);
    end
    csr_do(OP_RS, A_MIP, 32'h0, 32'h0000_0800, 1'b0, 1, "mip_read");
    irq_ext_i = 1'b0;
    idle();
  endtask

  task automatic test_counters();
    csr_do(OP_RW, A_MCYCLE, 32'hFFFF_FFFF, 32'h0, 1'b0, 0, "mcycle_wr");
    idle();
    csr_do(OP_RS, A_MCYCLEH, 32'h0, 32'h1, 1'b0, 1, "mcycleh_carry");
    checks++;
    if (rdata32 !== 32'h0 || rvalid32 !== 1'b1) begin
      errors++;
      $display("FAIL mcycleh_w32: got rdata %h rvalid %b expected 0 1", rdata32, rvalid32);
    end
    csr_do(OP_RS, A_MCYCLE, 32'h0, 32'h1, 1'b0, 1, "mcycle_after");
    csr_do(OP_RW, A_MCYCLEH, 32'hFFFF_FFFF, 32'h1, 1'b0, 1, "mcycleh_wr");
    csr_do(OP_RW, A_MCYCLE, 32'hFFFF_FFFF, 32'h0, 1'b0, 0, "mcycle_wr2");
    csr_do(OP_RS, A_MCYCLEH, 32'h0, 32'hFFFF_FFFF, 1'b0, 1, "mcycleh_full");
    csr_do(OP_RS, A_MCYCLE, 32'h0, 32'h0, 1'b0, 1, "mcycle_wrap");
    csr_do(OP_RS, A_MCYCLEH, 32'h0, 32'h0, 1'b0, 1, "mcycleh_wrap");
    retire_i = 1'b1;
    csr_do(OP_RW, A_MINSTRET, 32'h5, 32'h0, 1'b0, 1, "minstret_wr");
    idle();
    idle();
    idle();
    retire_i = 1'b0;
    csr_do(OP_RS, A_MINSTRET, 32'h0, 32'h8, 1'b0, 1, "minstret_count");
    csr_do(OP_RS, A_MINSTRETH, 32'h0, 32'h0, 1'b0, 1, "minstreth");
    idle();
  endtask

  task automatic test_back_to_back();
    csr_do(OP_RW, A_MSCRATCH, 32'hA5A5_0000, 32'h1234_5677, 1'b0, 1, "b2b_0");
    csr_do(OP_RW, A_MSCRATCH, 32'h0000_5A5A, 32'hA5A5_0000, 1'b0, 1, "b2b_1");
    csr_do(OP_RS, A_MSCRATCH, 32'hF000_0000, 32'h0000_5A5A, 1'b0, 1, "b2b_2");
    csr_do(OP_RC, A_MSCRATCH, 32'h0000_5A5A, 32'hF000_5A5A, 1'b0, 1, "b2b_3");
    csr_do(OP_RS, A_MSCRATCH, 32'h0, 32'hF000_0000, 1'b0, 1, "b2b_4");
    idle();
  endtask

  task automatic test_reset_mid();
    csr_req_i = 1'b1; csr_op_i = OP_RW; csr_addr_i = A_MSCRATCH; csr_wdata_i = 32'h77;
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    csr_req_i = 1'b0;
    csr_op_i  = OP_NONE;
    #1;
    checks++;
    if (csr_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: got rvalid %b expected 0", csr_rvalid_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (csr_rvalid_o !== 1'b0 || mepc_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_release: got rvalid %b mepc %h expected 0 0", csr_rvalid_o, mepc_o);
    end
    @(negedge clk);
    csr_do(OP_RS, A_MSCRATCH, 32'h0, 32'h0, 1'b0, 1, "mscratch_after_reset");
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    csr_req_i = 1'b0; csr_op_i = OP_NONE; csr_addr_i = '0; csr_wdata_i = '0;
    retire_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0;
    trap_cause_i = '0; trap_pc_i = '0; trap_tval_i = '0;
    irq_sw_i = 1'b0; irq_timer_i = 1'b0; irq_ext_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_rw_rs_rc();
    test_idle_hold();
    test_illegal();
    test_fields();
    test_trap_mret();
    test_collision();
    test_irq();
    test_counters();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
